// File: rtl/pc_npc_sequencer_pkg.sv
// Shared types and constants for the PC/nPC fetch sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } seq_state_e;

    localparam logic [31:0] PC_INCR    = 32'd4;
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] align_addr(input logic [31:0] a);
        return a & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/pc_npc_sequencer_if.sv
// Request/response bundle between the hazard/ID logic and the PC/nPC sequencer.
interface pc_npc_sequencer_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        redirect;
    logic [31:0] redirect_vector;
    logic        halt_req;
    logic [31:0] pc_out;
    logic [31:0] npc_out;
    logic        le_pc;
    logic        le_npc;
    logic        fetch_valid;
    logic        flush;
    logic        misalign_err;
    logic [1:0]  state_out;

    modport master (
        output stall, branch_taken, branch_target, redirect, redirect_vector, halt_req,
        input  pc_out, npc_out, le_pc, le_npc, fetch_valid, flush, misalign_err, state_out
    );

    modport slave (
        input  stall, branch_taken, branch_target, redirect, redirect_vector, halt_req,
        output pc_out, npc_out, le_pc, le_npc, fetch_valid, flush, misalign_err, state_out
    );
endinterface

// File: rtl/pc_npc_sequencer_regs.sv
// PC and nPC registers with independent load enables and synchronous active-low reset.
module pc_npc_regs
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        le_pc_i,
    input  logic        le_npc_i,
    input  logic [31:0] pc_d_i,
    input  logic [31:0] npc_d_i,
    output logic [31:0] pc_q_o,
    output logic [31:0] npc_q_o
);

    logic [31:0] pc_q, npc_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pc_q  <= RESET_PC;
            npc_q <= RESET_PC + PC_INCR;
        end else begin
            if (le_pc_i)  pc_q  <= pc_d_i;
            if (le_npc_i) npc_q <= npc_d_i;
        end
    end

    assign pc_q_o  = pc_q;
    assign npc_q_o = npc_q;

endmodule

// File: rtl/pc_npc_sequencer.sv
// Fetch-stage PC/nPC sequencer: post-reset hold, delayed branches, stalls, halt and
// non-delayed exception redirects, with registered flush/misalign pulses.
module pc_npc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          HOLD_CYCLES = 2
) (
    input  logic           clk,
    input  logic           reset,
    pc_npc_sequencer_if.slave bus
);

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    seq_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        flush_q, flush_d;
    logic        mis_q, mis_d;
    logic [31:0] pc_q, npc_q, pc_d, npc_d;
    logic        le_pc, le_npc, fetch_valid;
    logic [31:0] redir_pc;

    assign redir_pc = align_addr(bus.redirect_vector);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            flush_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            mis_q   <= mis_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_d        = npc_q;
        npc_d       = npc_q + PC_INCR;
        le_pc       = 1'b0;
        le_npc      = 1'b0;
        fetch_valid = 1'b0;
        flush_d     = 1'b0;
        mis_d       = 1'b0;
        case (state_q)
            ST_HOLD: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == HOLD_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                fetch_valid = !bus.stall;
                if (bus.redirect) begin
                    pc_d    = redir_pc;
                    npc_d   = redir_pc + PC_INCR;
                    le_pc   = 1'b1;
                    le_npc  = 1'b1;
                    flush_d = 1'b1;
                    mis_d   = |bus.redirect_vector[1:0];
                end else if (bus.halt_req) begin
                    state_d = ST_HALTED;
                end else if (!bus.stall) begin
                    // Delay slot: pc still advances to the old npc; only npc takes the target.
                    le_pc  = 1'b1;
                    le_npc = 1'b1;
                    if (bus.branch_taken) begin
                        npc_d = align_addr(bus.branch_target);
                        mis_d = |bus.branch_target[1:0];
                    end
                end
            end
            ST_HALTED: begin
                if (bus.redirect) begin
                    state_d = ST_RUN;
                    pc_d    = redir_pc;
                    npc_d   = redir_pc + PC_INCR;
                    le_pc   = 1'b1;
                    le_npc  = 1'b1;
                    flush_d = 1'b1;
                    mis_d   = |bus.redirect_vector[1:0];
                end
            end
            default: state_d = ST_HOLD;
        endcase
        if (!reset) begin
            le_pc       = 1'b0;
            le_npc      = 1'b0;
            fetch_valid = 1'b0;
        end
    end

    pc_npc_regs #(.RESET_PC(RESET_PC)) u_regs (
        .clk_i    (clk),
        .rst_ni   (reset),
        .le_pc_i  (le_pc),
        .le_npc_i (le_npc),
        .pc_d_i   (pc_d),
        .npc_d_i  (npc_d),
        .pc_q_o   (pc_q),
        .npc_q_o  (npc_q)
    );

    assign bus.pc_out       = pc_q;
    assign bus.npc_out      = npc_q;
    assign bus.le_pc        = le_pc;
    assign bus.le_npc       = le_npc;
    assign bus.fetch_valid  = fetch_valid;
    assign bus.flush        = flush_q;
    assign bus.misalign_err = mis_q;
    assign bus.state_out    = state_q;

endmodule

// File: tb/tb_pc_npc_sequencer.sv
// Directed table-driven bench for pc_npc_sequencer plus hand sequences for priority corners.
module tb_pc_npc_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pc_npc_sequencer_if bus();

    pc_npc_sequencer #(.RESET_PC(32'h0), .HOLD_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        rd;
        logic [31:0] vec;
        logic        halt;
        logic [31:0] e_pc;
        logic [31:0] e_npc;
        logic [1:0]  e_st;
        logic        e_fv;
        logic        e_le;
        logic        e_fl;
        logic        e_mi;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic stall, input logic br, input logic [31:0] tgt,
                       input logic rd, input logic [31:0] vec, input logic halt,
                       input logic [31:0] pc, input logic [31:0] npc, input logic [1:0] st,
                       input logic fv, input logic le, input logic fl, input logic mi);
        vec_t v;
        v.rst = rst; v.stall = stall; v.br = br; v.tgt = tgt; v.rd = rd; v.vec = vec; v.halt = halt;
        v.e_pc = pc; v.e_npc = npc; v.e_st = st; v.e_fv = fv; v.e_le = le; v.e_fl = fl; v.e_mi = mi;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic stall, input logic br, input logic [31:0] tgt,
                         input logic rd, input logic [31:0] vec, input logic halt);
        reset               = rst;
        bus.stall           = stall;
        bus.branch_taken    = br;
        bus.branch_target   = tgt;
        bus.redirect        = rd;
        bus.redirect_vector = vec;
        bus.halt_req        = halt;
    endtask

    initial begin
        //  rst st br tgt            rd vec            hl  pc             npc            st fv le fl mi
        add(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h4,         0, 0, 0, 0, 0);
        add(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h4,         0, 0, 0, 0, 0);
        add(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h4,         0, 0, 0, 0, 0);
        add(1, 0, 0, 32'h0,         1, 32'h500,       0, 32'h0,         32'h4,         0, 0, 0, 0, 0);
        add(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h4,         1, 1, 1, 0, 0);
        add(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h4,         32'h8,         1, 1, 1, 0, 0);
        add(1, 0, 1, 32'h100,       0, 32'h0,         0, 32'h8,         32'hC,         1, 1, 1, 0, 0);
        add(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'hC,         32'h100,       1, 1, 1, 0, 0);
        add(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h100,       32'h104,       1, 1, 1, 0, 0);
        add(1, 0, 0, 32'h0,         1, 32'h20,        0, 32'h104,       32'h108,       1, 1, 1, 0, 0);
        add(1, 1, 1, 32'h200,       0, 32'h0,         0, 32'h20,        32'h24,        1, 0, 0, 1, 0);
        add(1, 1, 1, 32'h200,       0, 32'h0,         0, 32'h20,        32'h24,        1, 0, 0, 0, 0);
        add(1, 0, 1, 32'h200,       0, 32'h0,         0, 32'h20,        32'h24,        1, 1, 1, 0, 0);
        add(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h24,        32'h200,       1, 1, 1, 0, 0);
        add(1, 0, 1, 32'h300,       1, 32'h8000_0182, 0, 32'h200,       32'h204,       1, 1, 1, 0, 0);
        add(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h8000_0180, 32'h8000_0184, 1, 1, 1, 1, 1);
        add(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h8000_0184, 32'h8000_0188, 1, 1, 1, 0, 0);
        add(1, 0, 1, 32'h402,       0, 32'h0,         0, 32'h8000_0188, 32'h8000_018C, 1, 1, 1, 0, 0);
        add(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h8000_018C, 32'h400,       1, 1, 1, 0, 1);
        add(1, 0, 0, 32'h0,         1, 32'h40,        0, 32'h400,       32'h404,       1, 1, 1, 0, 0);
        add(1, 0, 0, 32'h0,         1, 32'h60,        0, 32'h40,        32'h44,        1, 1, 1, 1, 0);
        add(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h60,        32'h64,        1, 1, 1, 1, 0);
        add(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h64,        32'h68,        1, 1, 1, 0, 0);
        add(1, 0, 0, 32'h0,         0, 32'h0,         1, 32'h68,        32'h6C,        1, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            add(1, i == 3, i == 5, 32'h700, 0, 32'h0, i == 7, 32'h68, 32'h6C, 2, 0, 0, 0, 0);
        add(1, 0, 0, 32'h0,         1, 32'h80,        0, 32'h68,        32'h6C,        2, 0, 1, 0, 0);
        add(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h80,        32'h84,        1, 1, 1, 1, 0);
        add(1, 0, 0, 32'h0,         1, 32'h3C,        0, 32'h84,        32'h88,        1, 1, 1, 0, 0);
        add(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h3C,        32'h40,        1, 1, 1, 1, 0);
        add(0, 0, 0, 32'h0,         1, 32'h900,       0, 32'h40,        32'h44,        1, 0, 0, 0, 0);
        add(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h4,         0, 0, 0, 0, 0);
        add(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h4,         0, 0, 0, 0, 0);
        add(1, 0, 0, 32'h0,         1, 32'hFFFF_FFF8, 0, 32'h0,         32'h4,         1, 1, 1, 0, 0);
        add(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 1, 1, 1, 1, 0);
        add(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'hFFFF_FFFC, 32'h0,         1, 1, 1, 0, 0);
        add(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h4,         1, 1, 1, 0, 0);

        drive(0, 0, 0, 32'h0, 0, 32'h0, 0);
        @(posedge clk);

        for (int r = 0; r < tbl.size(); r++) begin
            @(negedge clk);
            drive(tbl[r].rst, tbl[r].stall, tbl[r].br, tbl[r].tgt, tbl[r].rd, tbl[r].vec, tbl[r].halt);
            #1;
            chk("pc",     r, bus.pc_out,              tbl[r].e_pc);
            chk("npc",    r, bus.npc_out,             tbl[r].e_npc);
            chk("state",  r, 32'(bus.state_out),      32'(tbl[r].e_st));
            chk("fvalid", r, 32'(bus.fetch_valid),    32'(tbl[r].e_fv));
            chk("le_pc",  r, 32'(bus.le_pc),          32'(tbl[r].e_le));
            chk("le_npc", r, 32'(bus.le_npc),         32'(tbl[r].e_le));
            chk("flush",  r, 32'(bus.flush),          32'(tbl[r].e_fl));
            chk("misal",  r, 32'(bus.misalign_err),   32'(tbl[r].e_mi));
            @(posedge clk);
        end

        // Redirect outranks stall; halt outranks stall.
        @(negedge clk);
        drive(1, 1, 0, 32'h0, 1, 32'h1000, 0);
        #1;
        chk("rd_stall_le", 100, 32'(bus.le_pc),       32'd1);
        chk("rd_stall_fv", 100, 32'(bus.fetch_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1, 0, 32'h0, 0, 32'h0, 1);
        #1;
        chk("rd_stall_pc",  101, bus.pc_out,          32'h1000);
        chk("rd_stall_npc", 101, bus.npc_out,         32'h1004);
        chk("rd_stall_fl",  101, 32'(bus.flush),      32'd1);
        chk("halt_stall_le",101, 32'(bus.le_npc),     32'd0);
        @(posedge clk);
        @(negedge clk);
        drive(1, 0, 0, 32'h0, 0, 32'h0, 0);
        #1;
        chk("halt_stall_st", 102, 32'(bus.state_out), 32'd2);
        chk("halt_stall_pc", 102, bus.pc_out,         32'h1000);
        chk("halt_fl_drop",  102, 32'(bus.flush),     32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
